ntt_bfu_pipe: RTL and testbench

// - Pipelined radix-2 NTT butterfly; consumes operand pairs read from the ping-pong RAMs at the read addresses issued by the address generator.
// - Produces the butterfly result pair plus the write address for the destination RAM bank.
// - One butterfly accepted per clock. Fixed latency. No backpressure.

---
 rtl/ntt_bfu_pipe_if.sv | 39 +++
 rtl/ntt_bfu_pipe.sv | 133 +++++++++++++
 tb/tb_ntt_bfu_pipe.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ntt_bfu_pipe_if.sv
// Operand/result bus for the NTT butterfly; master drives operands, slave returns results.
// BFU_INTT_EN adds the per-beat mode bit.
interface ntt_bfu_pipe_if #(
  parameter int unsigned DW = 14,
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 16
);
  logic              clr;
  logic              in_valid;
  logic [DW-1:0]     a;
  logic [DW-1:0]     b;
  logic [DW-1:0]     w;
  logic [2*AW-1:0]   in_addr;
`ifdef BFU_INTT_EN
  logic              mode;
`endif
  logic              out_valid;
  logic [DW-1:0]     x;
  logic [DW-1:0]     y;
  logic [2*AW-1:0]   out_addr;
  logic              busy;
  logic [CW-1:0]     done_cnt;

  modport master (
`ifdef BFU_INTT_EN
    output mode,
`endif
    output clr, in_valid, a, b, w, in_addr,
    input  out_valid, x, y, out_addr, busy, done_cnt
  );

  modport slave (
`ifdef BFU_INTT_EN
    input  mode,
`endif
    input  clr, in_valid, a, b, w, in_addr,
    output out_valid, x, y, out_addr, busy, done_cnt
  );
endinterface

// File: rtl/ntt_bfu_pipe.sv
// Pipelined radix-2 NTT butterfly with Barrett reduction, fixed 4-edge latency, no backpressure.
// BFU_INTT_EN: adds per-beat Gentleman-Sande mode (bus.mode=1) alongside Cooley-Tukey.
module ntt_bfu_pipe #(
  parameter int unsigned DW = 14,
  parameter int unsigned Q  = 12289,
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 16
) (
  input logic         clk,
  input logic         reset,
  ntt_bfu_pipe_if.slave bus
);
  localparam int unsigned PW = 2 * DW;
  localparam logic [PW:0]   R_ONE = {1'b1, {PW{1'b0}}};
  localparam logic [PW-1:0] BM    = PW'(R_ONE / (PW + 1)'(Q));
  localparam logic [DW:0]   QD    = (DW + 1)'(Q);
  localparam logic [PW-1:0] QP    = PW'(Q);

  function automatic logic [DW-1:0] add_mod(input logic [DW-1:0] u, input logic [DW-1:0] v);
    logic [DW:0] s;
    s = {1'b0, u} + {1'b0, v};
    return (s >= QD) ? DW'(s - QD) : DW'(s);
  endfunction

  function automatic logic [DW-1:0] sub_mod(input logic [DW-1:0] u, input logic [DW-1:0] v);
    logic [DW:0] d;
    d = {1'b0, u} + QD - {1'b0, v};
    return (u >= v) ? (u - v) : DW'(d);
  endfunction

  logic mode_in;
`ifdef BFU_INTT_EN
  assign mode_in = bus.mode;
`else
  assign mode_in = 1'b0;
`endif

  // Rank 0 registers the raw operands; the product is formed from these so
  // that the result appears four edges after the sampling edge.
  logic              v0, m0;
  logic [DW-1:0]     a0, b0, w0;
  logic [2*AW-1:0]   addr0;
  logic              v1, m1;
  logic [DW-1:0]     top1;
  logic [PW-1:0]     p1;
  logic [2*AW-1:0]   addr1;
  logic              v2, m2;
  logic [DW-1:0]     top2;
  logic [PW-1:0]     p2, qh2;
  logic [2*AW-1:0]   addr2;
  logic              v3, m3;
  logic [DW-1:0]     top3, t3;
  logic [2*AW-1:0]   addr3;

  logic              out_valid_q;
  logic [DW-1:0]     x_q, y_q;
  logic [2*AW-1:0]   out_addr_q;
  logic [CW-1:0]     done_q;

  logic [DW-1:0]     mul_op, top_op;
  logic [2*PW-1:0]   pbm;
  logic [PW-1:0]     r0, r1, r2;

  always_comb begin
    mul_op = m0 ? sub_mod(a0, b0) : b0;
    top_op = m0 ? add_mod(a0, b0) : a0;
    pbm    = (2 * PW)'(p1) * (2 * PW)'(BM);
    r0     = p2 - qh2 * QP;
    r1     = (r0 >= QP) ? (r0 - QP) : r0;
    r2     = (r1 >= QP) ? (r1 - QP) : r1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {v0, v1, v2, v3, out_valid_q} <= '0;
      {m0, m1, m2, m3}              <= '0;
      {a0, b0, w0, top1, top2, top3, t3} <= '0;
      {addr0, addr1, addr2, addr3}  <= '0;
      {p1, p2, qh2}                 <= '0;
      x_q        <= '0;
      y_q        <= '0;
      out_addr_q <= '0;
      done_q     <= '0;
    end else begin
      a0    <= bus.a;
      b0    <= bus.b;
      w0    <= bus.w;
      addr0 <= bus.in_addr;
      m0    <= mode_in;

      top1  <= top_op;
      p1    <= {{DW{1'b0}}, mul_op} * {{DW{1'b0}}, w0};
      addr1 <= addr0;
      m1    <= m0;

      top2  <= top1;
      p2    <= p1;
      qh2   <= pbm[2*PW-1:PW];
      addr2 <= addr1;
      m2    <= m1;

      top3  <= top2;
      t3    <= r2[DW-1:0];
      addr3 <= addr2;
      m3    <= m2;

      // clr drops the beat that would have emerged on this edge, uncounted
      if (bus.clr) begin
        {v0, v1, v2, v3, out_valid_q} <= '0;
        done_q <= '0;
      end else begin
        v0          <= bus.in_valid;
        v1          <= v0;
        v2          <= v1;
        v3          <= v2;
        out_valid_q <= v3;
        done_q      <= done_q + CW'(v3);
        if (v3) begin
          x_q        <= m3 ? top3 : add_mod(top3, t3);
          y_q        <= m3 ? t3 : sub_mod(top3, t3);
          out_addr_q <= addr3;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.busy      = v0 | v1 | v2 | v3 | out_valid_q;
  assign bus.done_cnt  = done_q;
endmodule

// File: tb/tb_ntt_bfu_pipe.sv
// Scoreboard bench for ntt_bfu_pipe: expected beats queued at drive time, checked on emergence.
module tb_ntt_bfu_pipe;
  localparam int unsigned DW = 14;
  localparam int unsigned Q  = 12289;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 16;

  typedef struct {
    logic [DW-1:0]   x;
    logic [DW-1:0]   y;
    logic [2*AW-1:0] addr;
    int unsigned     due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [CW-1:0] exp_done = '0;
  exp_t sb[$];

  ntt_bfu_pipe_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();
  ntt_bfu_pipe #(.DW(DW), .Q(Q), .AW(AW), .CW(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int unsigned a, input int unsigned b, input int unsigned w,
                                input logic m, output logic [DW-1:0] ex, output logic [DW-1:0] ey);
    int unsigned t, d;
    if (m) begin
      d  = (a + Q - b) % Q;
      ex = DW'((a + b) % Q);
      ey = DW'((d * w) % Q);
    end else begin
      t  = (w * b) % Q;
      ex = DW'((a + t) % Q);
      ey = DW'((a + Q - t) % Q);
    end
  endfunction

  // Checker: every negedge, compare out_valid/busy/done_cnt and any due result.
  always @(negedge clk) begin
    exp_t e;
    logic ev;
    ev = (sb.size() > 0) && (sb[0].due == cyc);
    chk("busy", 32'(bus.busy), 32'(sb.size() > 0));
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    if (ev) begin
      e = sb.pop_front();
      exp_done = exp_done + 1'b1;
      if (bus.out_valid === 1'b1) begin
        chk("x", 32'(bus.x), 32'(e.x));
        chk("y", 32'(bus.y), 32'(e.y));
        chk("out_addr", 32'(bus.out_addr), 32'(e.addr));
      end
    end
    chk("done_cnt", 32'(bus.done_cnt), 32'(exp_done));
  end

  task automatic beat(input logic [DW-1:0] a_i, input logic [DW-1:0] b_i, input logic [DW-1:0] w_i,
                      input logic [2*AW-1:0] ad, input logic m,
                      input logic [DW-1:0] ex, input logic [DW-1:0] ey);
    @(negedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a = a_i; bus.b = b_i; bus.w = w_i; bus.in_addr = ad;
`ifdef BFU_INTT_EN
    bus.mode = m;
`else
    if (m) $display("mode beat ignored in CT-only build");
`endif
    sb.push_back('{ex, ey, ad, cyc + 5});
  endtask

  task automatic rbeat(input logic m);
    logic [DW-1:0] ra, rb, rw, ex, ey;
    logic [2*AW-1:0] ad;
    ra = DW'($urandom_range(Q - 1, 0));
    rb = DW'($urandom_range(Q - 1, 0));
    rw = DW'($urandom_range(Q - 1, 0));
    ad = (2*AW)'($urandom);
    model(ra, rb, rw, m, ex, ey);
    beat(ra, rb, rw, ad, m, ex, ey);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    chk("drain", 32'(sb.size()), 32'd0);
    idle(1);
  endtask

  initial begin
    logic rm;
    reset = 1'b1;
    bus.clr = 1'b0; bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.w = '0; bus.in_addr = '0;
`ifdef BFU_INTT_EN
    bus.mode = 1'b0;
`endif
    idle(2);
    chk("rst_x", 32'(bus.x), 0);
    chk("rst_y", 32'(bus.y), 0);
    chk("rst_addr", 32'(bus.out_addr), 0);
    reset = 1'b0;
    idle(1);

    // CT basic and modular wrap cases, back to back
    beat(14'd1, 14'd2, 14'd3, 16'hA55A, 1'b0, 14'd7, 14'd12284);
    beat(14'd0, 14'd12288, 14'd12288, 16'h0102, 1'b0, 14'd1, 14'd12288);
    beat(14'd12288, 14'd1, 14'd1, 16'hFFFF, 1'b0, 14'd0, 14'd12287);
    drain();

    // Reset with three beats in flight
    rbeat(1'b0); rbeat(1'b0); rbeat(1'b0);
    @(negedge clk); #1;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    exp_done = '0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_x", 32'(bus.x), 0);
    chk("mid_rst_y", 32'(bus.y), 0);
    chk("mid_rst_addr", 32'(bus.out_addr), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done_cnt), 0);
    idle(2);
    reset = 1'b0;
    idle(8);

    // Stream 256 random beats, one bubble before beat 100
    for (int unsigned i = 0; i < 256; i++) begin
      if (i == 100) idle(1);
`ifdef BFU_INTT_EN
      rm = 1'($urandom_range(1, 0));
`else
      rm = 1'b0;
`endif
      rbeat(rm);
    end
    drain();
    chk("stream_done_cnt", 32'(bus.done_cnt), 32'd256);

    // clr with in_valid high and two beats in flight
    rbeat(1'b0); rbeat(1'b0);
    @(negedge clk); #1;
    bus.clr = 1'b1;
    bus.in_valid = 1'b1;
    sb.delete();
    exp_done = '0;
    @(negedge clk); #1;
    bus.clr = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_busy", 32'(bus.busy), 0);
    chk("clr_done", 32'(bus.done_cnt), 0);
    idle(8);

`ifdef BFU_INTT_EN
    // GS beats interleaved with CT beats
    beat(14'd5, 14'd7, 14'd2, 16'h1234, 1'b1, 14'd12, 14'd12285);
    beat(14'd1, 14'd2, 14'd3, 16'h4321, 1'b0, 14'd7, 14'd12284);
    beat(14'd5, 14'd7, 14'd2, 16'h5555, 1'b1, 14'd12, 14'd12285);
    rbeat(1'b0); rbeat(1'b1); rbeat(1'b0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
